a5_keystream_ctrl: RTL and testbench

Wishbone-slave sequencer for the A5/1 keystream core.
- Holds the key and frame registers and runs the fixed A5/1 schedule: clear, 64 key steps, 22 frame steps, 100 mix steps, 228 generate steps.
- Captures the keystream into a readable buffer and flags completion.
- Sits between the Caravel Wishbone port and a separate LFSR core (a5_lfsr_core), which it drives step by step.

---
 rtl/a5_pkg.sv | 37 +++
 rtl/a5_ks_buffer.sv | 29 ++
 rtl/a5_keystream_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_a5_keystream_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/a5_pkg.sv
// Shared definitions for the A5/1 keystream sequencer: FSM states,
// register indices and the fixed load-schedule lengths.
package a5_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    KEY,
    FRAME,
    MIX,
    GEN,
    DRAIN
  } state_t;

  // Register indices as decoded from wbs_adr_i[5:2]
  localparam logic [3:0] REG_CTRL   = 4'd0;
  localparam logic [3:0] REG_STATUS = 4'd1;
  localparam logic [3:0] REG_KEY_LO = 4'd2;
  localparam logic [3:0] REG_KEY_HI = 4'd3;
  localparam logic [3:0] REG_FRAME  = 4'd4;

  localparam int unsigned KEY_STEPS   = 64;
  localparam int unsigned FRAME_STEPS = 22;

  // Replace only the byte lanes selected by sel
  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] wdat,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = cur;
    for (int unsigned b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = wdat[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/a5_ks_buffer.sv
// 8x32 keystream capture buffer: synchronous clear, single-bit write by
// bit index (bit n -> word n/32, bit n%32), combinational word read.
module a5_ks_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        wr_en,
  input  logic [7:0]  wr_idx,
  input  logic        wr_bit,
  input  logic [2:0]  rd_word,
  output logic [31:0] rd_data
);

  logic [7:0][31:0] mem;

  // Bit capture with whole-buffer clear taking priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else if (clr) begin
      mem <= '0;
    end else if (wr_en) begin
      mem[wr_idx[7:5]][wr_idx[4:0]] <= wr_bit;
    end
  end

  assign rd_data = mem[rd_word];

endmodule

// File: rtl/a5_keystream_ctrl.sv
// Wishbone slave and step sequencer for an external A5/1 LFSR core.
// Runs clear, key load, frame load, mix and generate phases, capturing
// the generated keystream into a readable buffer.
module a5_keystream_ctrl
  import a5_pkg::*;
#(
  parameter int unsigned MIX_STEPS = 100,
  parameter int unsigned KS_BITS   = 228
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        core_clr_o,
  output logic        core_step_all_o,
  output logic        core_step_maj_o,
  output logic        core_in_o,
  input  logic        core_out_i,
  output logic        busy_o,
  output logic        irq_o
);

  localparam logic [8:0] KEY_LAST   = 9'(KEY_STEPS - 1);
  localparam logic [8:0] FRAME_LAST = 9'(FRAME_STEPS - 1);
  localparam logic [8:0] MIX_LAST   = 9'(MIX_STEPS - 1);
  localparam logic [8:0] GEN_LAST   = 9'(KS_BITS - 1);
  localparam logic [7:0] KS_LAST    = 8'(KS_BITS - 1);

  state_t      state;
  logic [8:0]  cnt;
  logic        busy;
  logic        done;
  logic [31:0] key_lo;
  logic [31:0] key_hi;
  logic [21:0] frame;
  logic [63:0] key_w;
  logic [31:0] rd_mux;
  logic [31:0] ks_word;
  logic [3:0]  idx;
  logic        acc;
  logic        wr;
  logic        start_req;
  logic        abort_req;
  logic        ks_wr;
  logic [7:0]  ks_idx;
  logic        unused_adr;

  assign idx        = wbs_adr_i[5:2];
  assign unused_adr = ^{wbs_adr_i[31:6], wbs_adr_i[1:0]};
  assign acc        = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign wr         = acc & wbs_we_i;
  assign key_w      = {key_hi, key_lo};
  // Abort dominates start when both bits arrive in one write
  assign start_req  = wr && (idx == REG_CTRL) && wbs_dat_i[0] && !wbs_dat_i[1];
  assign abort_req  = wr && (idx == REG_CTRL) && wbs_dat_i[1];

  // Capture bit cnt-1 from the second GEN cycle, last bit in DRAIN
  assign ks_wr  = !abort_req && (((state == GEN) && (cnt != '0)) || (state == DRAIN));
  assign ks_idx = (state == DRAIN) ? KS_LAST : (cnt[7:0] - 8'd1);

  a5_ks_buffer u_ks_buffer (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clr     (start_req && (state == IDLE)),
    .wr_en   (ks_wr),
    .wr_idx  (ks_idx),
    .wr_bit  (core_out_i),
    .rd_word (idx[2:0]),
    .rd_data (ks_word)
  );

  // Read data selection by register index
  always_comb begin
    rd_mux = '0;
    case (idx)
      REG_STATUS: rd_mux = {30'd0, done, busy};
      REG_KEY_LO: rd_mux = key_lo;
      REG_KEY_HI: rd_mux = key_hi;
      REG_FRAME:  rd_mux = {10'd0, frame};
      default:    if (idx[3]) rd_mux = ks_word;
    endcase
  end

  // Wishbone handshake, read capture and register writes
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      key_lo    <= '0;
      key_hi    <= '0;
      frame     <= '0;
    end else begin
      wbs_ack_o <= acc;
      if (acc) wbs_dat_o <= wbs_we_i ? '0 : rd_mux;
      if (wr && !busy) begin
        case (idx)
          REG_KEY_LO: key_lo <= merge_bytes(key_lo, wbs_dat_i, wbs_sel_i);
          REG_KEY_HI: key_hi <= merge_bytes(key_hi, wbs_dat_i, wbs_sel_i);
          REG_FRAME:  frame  <= 22'(merge_bytes({10'd0, frame}, wbs_dat_i, wbs_sel_i));
          default: ;
        endcase
      end
    end
  end

  // Schedule FSM; strobes and core_in are registered for the entering state
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state           <= IDLE;
      cnt             <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      core_clr_o      <= 1'b0;
      core_step_all_o <= 1'b0;
      core_step_maj_o <= 1'b0;
      core_in_o       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_req) begin
            state      <= CLEAR;
            cnt        <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            core_clr_o <= 1'b1;
          end
        end
        default: begin
          if (abort_req) begin
            state           <= IDLE;
            cnt             <= '0;
            busy            <= 1'b0;
            core_clr_o      <= 1'b0;
            core_step_all_o <= 1'b0;
            core_step_maj_o <= 1'b0;
            core_in_o       <= 1'b0;
          end else begin
            case (state)
              CLEAR: begin
                state           <= KEY;
                cnt             <= '0;
                core_clr_o      <= 1'b0;
                core_step_all_o <= 1'b1;
                core_in_o       <= key_w[0];
              end
              KEY: begin
                if (cnt == KEY_LAST) begin
                  state     <= FRAME;
                  cnt       <= '0;
                  core_in_o <= frame[0];
                end else begin
                  cnt       <= cnt + 9'd1;
                  core_in_o <= key_w[cnt[5:0] + 6'd1];
                end
              end
              FRAME: begin
                if (cnt == FRAME_LAST) begin
                  state           <= MIX;
                  cnt             <= '0;
                  core_step_all_o <= 1'b0;
                  core_step_maj_o <= 1'b1;
                  core_in_o       <= 1'b0;
                end else begin
                  cnt       <= cnt + 9'd1;
                  core_in_o <= frame[cnt[4:0] + 5'd1];
                end
              end
              MIX: begin
                if (cnt == MIX_LAST) begin
                  state <= GEN;
                  cnt   <= '0;
                end else begin
                  cnt <= cnt + 9'd1;
                end
              end
              GEN: begin
                if (cnt == GEN_LAST) begin
                  state           <= DRAIN;
                  cnt             <= '0;
                  core_step_maj_o <= 1'b0;
                end else begin
                  cnt <= cnt + 9'd1;
                end
              end
              DRAIN: begin
                state <= IDLE;
                cnt   <= '0;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign busy_o = busy;
  assign irq_o  = done;

endmodule

// File: tb/tb_a5_keystream_ctrl.sv
// Directed bench for a5_keystream_ctrl with a behavioural A5/1 core
// attached to the step strobes and a reference keystream function.
module tb_a5_keystream_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] dat_i, adr, dat_o;
  logic        ack;
  logic        core_clr, core_all, core_maj, core_in, core_out;
  logic        busy, irq;

  int unsigned total = 0;
  int unsigned bad   = 0;

  a5_keystream_ctrl #(.MIX_STEPS(100), .KS_BITS(228)) dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .wbs_stb_i       (stb),
    .wbs_cyc_i       (cyc),
    .wbs_we_i        (we),
    .wbs_sel_i       (sel),
    .wbs_dat_i       (dat_i),
    .wbs_adr_i       (adr),
    .wbs_ack_o       (ack),
    .wbs_dat_o       (dat_o),
    .core_clr_o      (core_clr),
    .core_step_all_o (core_all),
    .core_step_maj_o (core_maj),
    .core_in_o       (core_in),
    .core_out_i      (core_out),
    .busy_o          (busy),
    .irq_o           (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // A5/1 register helpers
  function automatic logic fb1(input logic [18:0] r); return r[13] ^ r[16] ^ r[17] ^ r[18]; endfunction
  function automatic logic fb2(input logic [21:0] r); return r[20] ^ r[21]; endfunction
  function automatic logic fb3(input logic [22:0] r); return r[7] ^ r[20] ^ r[21] ^ r[22]; endfunction
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Behavioural LFSR core reacting to the controller strobes
  logic [18:0] r1 = '0;
  logic [21:0] r2 = '0;
  logic [22:0] r3 = '0;
  logic [85:0] seq = '0;
  int          nall = 0;
  logic        m;
  assign core_out = r1[18] ^ r2[21] ^ r3[22];

  always @(posedge clk) begin
    if (core_clr) begin
      r1 <= '0; r2 <= '0; r3 <= '0;
      nall <= 0;
    end else if (core_all) begin
      r1 <= {r1[17:0], fb1(r1) ^ core_in};
      r2 <= {r2[20:0], fb2(r2) ^ core_in};
      r3 <= {r3[21:0], fb3(r3) ^ core_in};
      if (nall < 86) seq[nall] <= core_in;
      nall <= nall + 1;
    end else if (core_maj) begin
      m = maj3(r1[8], r2[10], r3[10]);
      if (r1[8]  == m) r1 <= {r1[17:0], fb1(r1)};
      if (r2[10] == m) r2 <= {r2[20:0], fb2(r2)};
      if (r3[10] == m) r3 <= {r3[21:0], fb3(r3)};
    end
  end

  // Strobe / busy cycle counters sampled mid-cycle
  int  n_busy, n_all, n_maj, n_clr;
  logic cnt_clr = 1'b1;
  always @(negedge clk) begin
    if (cnt_clr) begin
      n_busy = 0; n_all = 0; n_maj = 0; n_clr = 0;
    end else begin
      if (busy)     n_busy++;
      if (core_all) n_all++;
      if (core_maj) n_maj++;
      if (core_clr) n_clr++;
    end
  end

  // Reference keystream: clear, key, frame, 100 mix, 228 output bits
  function automatic logic [255:0] ref_ks(input logic [63:0] k, input logic [21:0] f);
    logic [18:0] a;
    logic [21:0] b;
    logic [22:0] c;
    logic        mm;
    logic [255:0] ks;
    a = '0; b = '0; c = '0; ks = '0;
    for (int i = 0; i < 86; i++) begin
      mm = (i < 64) ? k[i] : f[i-64];
      a = {a[17:0], fb1(a) ^ mm};
      b = {b[20:0], fb2(b) ^ mm};
      c = {c[21:0], fb3(c) ^ mm};
    end
    for (int i = 0; i < 328; i++) begin
      mm = maj3(a[8], b[10], c[10]);
      if (a[8]  == mm) a = {a[17:0], fb1(a)};
      if (b[10] == mm) b = {b[20:0], fb2(b)};
      if (c[10] == mm) c = {c[21:0], fb3(c)};
      if (i >= 100) ks[i-100] = a[18] ^ b[21] ^ c[22];
    end
    return ks;
  endfunction

  task automatic clear_counts();
    cnt_clr = 1'b1;
    @(negedge clk);
    #1 cnt_clr = 1'b0;
  endtask

  task automatic wb_xfer(input logic wr, input logic [3:0] ri, input logic [31:0] wd,
                         input logic [3:0] s, output logic [31:0] rd);
    logic got;
    got = 1'b0;
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = wr; adr = {26'd0, ri, 2'b00}; dat_i = wd; sel = s;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) got = 1'b1;
    end
    check("wb_ack", got, 1);
    rd = dat_o;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wb_wr(input logic [3:0] ri, input logic [31:0] wd, input logic [3:0] s);
    logic [31:0] dummy;
    wb_xfer(1'b1, ri, wd, s, dummy);
  endtask

  task automatic wb_rd(input logic [3:0] ri, output logic [31:0] rd);
    wb_xfer(1'b0, ri, '0, 4'hF, rd);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("busy_timeout", busy, 0);
  endtask

  task automatic check_ks(input string tag, input logic [255:0] exp);
    logic [31:0] w;
    for (int i = 0; i < 8; i++) begin
      wb_rd(4'(8 + i), w);
      check($sformatf("%s_ks%0d", tag, i), w, exp[32*i +: 32]);
    end
  endtask

  logic [31:0]  rd;
  logic [63:0]  key_v;
  logic [255:0] exp_ks;

  initial begin
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = '0; dat_i = '0; adr = '0;
    key_v  = 64'h1223456789ABCDEF;
    exp_ks = ref_ks(key_v, 22'h134);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: reset state
    check("rst_busy", busy, 0);
    check("rst_irq", irq, 0);
    check("rst_strobes", {core_clr, core_all, core_maj, core_in}, 0);
    wb_rd(REG_STATUS_IDX(), rd); check("rst_status", rd, 0);
    wb_rd(4'd8, rd);             check("rst_ks0", rd, 0);
    wb_rd(4'd4, rd);             check("rst_frame", rd, 0);

    // 2: all-zero key/frame run
    clear_counts();
    wb_wr(4'd0, 32'h1, 4'hF);
    wait_idle();
    check("z_busy_cycles", n_busy, 416);
    check("z_all_cycles", n_all, 86);
    check("z_maj_cycles", n_maj, 328);
    check("z_clr_cycles", n_clr, 1);
    check_ks("z", '0);
    wb_rd(4'd1, rd); check("z_status", rd, 32'h2);
    check("z_irq", irq, 1);

    // 3: golden key/frame run, plus register boundary checks
    wb_wr(4'd2, 32'h89ABCDEF, 4'hF);
    wb_wr(4'd3, 32'h12234567, 4'hF);
    wb_wr(4'd4, 32'hFFC00134, 4'hF);
    wb_rd(4'd4, rd); check("frame_mask", rd, 32'h134);
    wb_rd(4'd5, rd); check("unmapped_rd", rd, 0);
    wb_wr(4'd0, 32'h3, 4'hF);
    @(negedge clk);
    check("start_abort_busy", busy, 0);
    wb_rd(4'd1, rd); check("start_abort_status", rd, 32'h2);
    clear_counts();
    wb_wr(4'd0, 32'h1, 4'hF);
    wait_idle();
    check("g_busy_cycles", n_busy, 416);
    check("g_in_seq", seq, {22'h134, key_v});
    check_ks("g", exp_ks);

    // 4: abort 150 cycles into a run
    wb_wr(4'd0, 32'h1, 4'hF);
    repeat (150) @(negedge clk);
    wb_wr(4'd0, 32'h2, 4'hF);
    check("abort_busy", busy, 0);
    check("abort_strobes", {core_clr, core_all, core_maj, core_in}, 0);
    wb_rd(4'd1, rd); check("abort_status", rd, 0);
    check("abort_irq", irq, 0);
    clear_counts();
    repeat (20) @(negedge clk);
    check("abort_quiet", n_all + n_maj + n_clr, 0);
    wb_rd(4'd2, rd); check("abort_key_lo", rd, 32'h89ABCDEF);
    wb_rd(4'd3, rd); check("abort_key_hi", rd, 32'h12234567);

    // 5: writes and restart while busy are ignored; byte-lane write
    clear_counts();
    wb_wr(4'd0, 32'h1, 4'hF);
    repeat (10) @(negedge clk);
    wb_wr(4'd2, 32'h0, 4'hF);
    wb_wr(4'd0, 32'h1, 4'hF);
    wait_idle();
    check("busywr_cycles", n_busy, 416);
    wb_rd(4'd2, rd); check("busywr_key_lo", rd, 32'h89ABCDEF);
    wb_rd(4'd8, rd); check("busywr_ks0", rd, exp_ks[31:0]);
    wb_wr(4'd2, 32'hFFFFFFFF, 4'b0010);
    wb_rd(4'd2, rd); check("sel_key_lo", rd, 32'h89ABFFEF);
    wb_wr(4'd2, 32'h89ABCDEF, 4'hF);

    // 6: asynchronous reset in the middle of GEN, then a clean rerun
    wb_wr(4'd0, 32'h1, 4'hF);
    repeat (200) @(negedge clk);
    check("pre_rst_maj", core_maj, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_busy", busy, 0);
    check("rst_async_irq", irq, 0);
    check("rst_async_strobes", {core_clr, core_all, core_maj, core_in}, 0);
    @(negedge clk);
    rst = 1'b0;
    wb_rd(4'd2, rd); check("post_rst_key_lo", rd, 0);
    wb_wr(4'd2, 32'h89ABCDEF, 4'hF);
    wb_wr(4'd3, 32'h12234567, 4'hF);
    wb_wr(4'd4, 32'h00000134, 4'hF);
    clear_counts();
    wb_wr(4'd0, 32'h1, 4'hF);
    wait_idle();
    check("rerun_cycles", n_busy, 416);
    check_ks("rerun", exp_ks);
    wb_rd(4'd1, rd); check("rerun_status", rd, 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic logic [3:0] REG_STATUS_IDX();
    return 4'd1;
  endfunction

endmodule
